nrs_re_buffer: RTL and testbench

- Demapper-side responder to the channel estimator's NRS read interface.
- Captures the 8 NRS resource elements (REs) of one NB-IoT subframe, port 0, from the post-FFT RE stream into a ping-pong (two-bank) store.
- Announces a complete subframe with demap_ready, serves demap_read/col_demap reads with registered rx_r/rx_i, and frees the bank on est_ack_demap.
- While the estimator reads one bank, the next subframe fills the other.

---
 rtl/nrs_re_buffer.sv | 190 +++++++++++++++++++
 tb/tb_nrs_re_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nrs_re_buffer.sv
// NRS resource-element ping-pong buffer: captures the 8 port-0 NRS REs of each
// NB-IoT subframe from the post-FFT stream and serves them to the channel estimator.
module nrs_re_buffer #(
    parameter int WIDTH_RX = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic                       in_last,
    input  logic [3:0]                 in_sym,
    input  logic [3:0]                 in_sc,
    input  logic signed [WIDTH_RX-1:0] in_r,
    input  logic signed [WIDTH_RX-1:0] in_i,
    input  logic [2:0]                 v_shift,
    input  logic                       demap_read,
    input  logic [3:0]                 col_demap,
    input  logic                       est_ack_demap,
    output logic signed [WIDTH_RX-1:0] rx_r,
    output logic signed [WIDTH_RX-1:0] rx_i,
    output logic                       demap_ready,
    output logic                       frame_err,
    output logic                       overflow
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0] bank_st [2];
    logic       wr_bank, rd_bank, cur_bank;
    logic [2:0] vs_q;
    logic [7:0] mask_q;
    logic       last_vld, rd_ptr;
    logic [1:0] last_col;

    logic signed [WIDTH_RX-1:0] mem_r [2][8];
    logic signed [WIDTH_RX-1:0] mem_i [2][8];

    logic       sof, filling, start_ok, start_bank, restart;
    logic       cap_active, cap_bank, col_ok, v_is3, hit_m0, hit_m1, hit;
    logic [2:0] vs_in, vs_eff, slot;
    logic [1:0] col;
    logic [3:0] k0_sum, k0;
    logic [7:0] mask_base, mask_new;
    logic       ack_fire, read_fire, rcol_ok, rd_m;
    logic [1:0] rcol;

    assign sof     = in_valid & in_sof;
    assign filling = (bank_st[cur_bank] == ST_FILLING);
    assign vs_in   = (v_shift >= 3'd6) ? v_shift - 3'd6 : v_shift;

    always_comb begin
        start_ok   = 1'b0;
        start_bank = wr_bank;
        restart    = 1'b0;
        if (filling) begin
            start_ok   = 1'b1;
            start_bank = cur_bank;
            restart    = 1'b1;
        end else if (bank_st[wr_bank] == ST_EMPTY) begin
            start_ok   = 1'b1;
            start_bank = wr_bank;
        end else if (bank_st[~wr_bank] == ST_EMPTY) begin
            start_ok   = 1'b1;
            start_bank = ~wr_bank;
        end
    end

    assign cap_active = sof ? start_ok : (in_valid & filling);
    assign cap_bank   = sof ? start_bank : cur_bank;
    assign vs_eff     = sof ? vs_in : vs_q;
    assign mask_base  = sof ? 8'd0 : mask_q;

    always_comb begin
        col    = 2'd0;
        col_ok = 1'b1;
        v_is3  = 1'b0;
        case (in_sym)
            4'd5:    col = 2'd0;
            4'd6:    begin col = 2'd1; v_is3 = 1'b1; end
            4'd12:   col = 2'd2;
            4'd13:   begin col = 2'd3; v_is3 = 1'b1; end
            default: col_ok = 1'b0;
        endcase
    end

    // NRS subcarrier pair for this symbol: k0 and k0+6
    assign k0_sum   = {1'b0, vs_eff} + (v_is3 ? 4'd3 : 4'd0);
    assign k0       = (k0_sum >= 4'd6) ? k0_sum - 4'd6 : k0_sum;
    assign hit_m0   = (in_sc == k0);
    assign hit_m1   = (in_sc == k0 + 4'd6);
    assign slot     = {col, hit_m1};
    assign hit      = cap_active & col_ok & (hit_m0 | hit_m1);
    assign mask_new = mask_base | (hit ? (8'b1 << slot) : 8'd0);

    assign ack_fire  = est_ack_demap & demap_ready;
    assign read_fire = demap_read & demap_ready;

    always_comb begin
        rcol    = 2'd0;
        rcol_ok = 1'b1;
        case (col_demap)
            4'd5:    rcol = 2'd0;
            4'd6:    rcol = 2'd1;
            4'd12:   rcol = 2'd2;
            4'd13:   rcol = 2'd3;
            default: rcol_ok = 1'b0;
        endcase
    end

    assign rd_m = (last_vld && last_col == rcol) ? rd_ptr : 1'b0;

    always_ff @(posedge clk) begin
        if (hit) begin
            mem_r[cap_bank][slot] <= in_r;
            mem_i[cap_bank][slot] <= in_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0]  <= ST_EMPTY;
            bank_st[1]  <= ST_EMPTY;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            cur_bank    <= 1'b0;
            vs_q        <= 3'd0;
            mask_q      <= 8'd0;
            last_vld    <= 1'b0;
            rd_ptr      <= 1'b0;
            last_col    <= 2'd0;
            rx_r        <= '0;
            rx_i        <= '0;
            demap_ready <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            if (sof) begin
                if (start_ok) begin
                    cur_bank <= start_bank;
                    vs_q     <= vs_in;
                    if (restart) frame_err <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (cap_active) begin
                mask_q <= mask_new;
                if (in_last) begin
                    if (mask_new == 8'hFF) begin
                        bank_st[cap_bank] <= ST_FULL;
                        wr_bank           <= ~cap_bank;
                    end else begin
                        bank_st[cap_bank] <= ST_EMPTY;
                        frame_err         <= 1'b1;
                    end
                end else begin
                    bank_st[cap_bank] <= ST_FILLING;
                end
            end
            // A write can never target the read bank, so the release below is independent
            if (ack_fire) begin
                bank_st[rd_bank] <= ST_EMPTY;
                rd_bank          <= ~rd_bank;
            end
            demap_ready <= ~ack_fire & (bank_st[rd_bank] == ST_FULL);
            if (read_fire) begin
                if (rcol_ok) begin
                    rx_r <= mem_r[rd_bank][{rcol, rd_m}];
                    rx_i <= mem_i[rd_bank][{rcol, rd_m}];
                    if (last_vld && last_col == rcol) begin
                        rd_ptr <= ~rd_ptr;
                    end else begin
                        last_col <= rcol;
                        last_vld <= 1'b1;
                        rd_ptr   <= 1'b1;
                    end
                end else begin
                    rx_r <= '0;
                    rx_i <= '0;
                end
            end
            if (ack_fire) last_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nrs_re_buffer.sv
// Directed bench for nrs_re_buffer: table-driven read checks plus hand sequences
// for ping-pong, overflow, incomplete subframes and reset.
module tb_nrs_re_buffer;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0, in_sof = 1'b0, in_last = 1'b0;
    logic [3:0]          in_sym = '0, in_sc = '0;
    logic signed [W-1:0] in_r = '0, in_i = '0;
    logic [2:0]          v_shift = '0;
    logic                demap_read = 1'b0, est_ack_demap = 1'b0;
    logic [3:0]          col_demap = '0;
    logic signed [W-1:0] rx_r, rx_i;
    logic                demap_ready, frame_err, overflow;

    int n_cmp = 0;
    int n_fail = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int ferr0, ovf0;

    typedef struct {
        logic [3:0] col;
        int         exp_r;
    } rd_vec_t;
    rd_vec_t tbl [10];

    nrs_re_buffer #(.WIDTH_RX(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_last(in_last),
        .in_sym(in_sym), .in_sc(in_sc), .in_r(in_r), .in_i(in_i), .v_shift(v_shift),
        .demap_read(demap_read), .col_demap(col_demap), .est_ack_demap(est_ack_demap),
        .rx_r(rx_r), .rx_i(rx_i), .demap_ready(demap_ready), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Pulse outputs are tallied so sequences can check how many occurred
    always @(posedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overflow) ovf_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drop_idx: linear RE index (sym*12+sc) to skip, -1 for none
    task automatic stream(input int vs, input int off, input int drop_idx, input bit do_last,
                          input int n_max);
        int last_idx;
        last_idx = (drop_idx == 167) ? 166 : 167;
        for (int idx = 0; idx < 168 && idx < n_max; idx++) begin
            if (idx != drop_idx) begin
                in_valid = 1'b1;
                in_sof   = (idx == 0);
                in_last  = do_last && (idx == last_idx);
                in_sym   = 4'(idx / 12);
                in_sc    = 4'(idx % 12);
                in_r     = W'(off + (idx / 12) * 16 + (idx % 12));
                in_i     = -in_r;
                v_shift  = 3'(vs);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_read(input int col, input bit ack);
        demap_read    = 1'b1;
        col_demap     = 4'(col);
        est_ack_demap = ack;
        @(negedge clk);
        demap_read    = 1'b0;
        est_ack_demap = 1'b0;
    endtask

    task automatic read_chk(input string name, input int col, input int exp_r);
        do_read(col, 1'b0);
        chk({name, "_r"}, rx_r, exp_r);
        chk({name, "_i"}, rx_i, -exp_r);
    endtask

    task automatic ack();
        est_ack_demap = 1'b1;
        @(negedge clk);
        est_ack_demap = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'd5, 82};   tbl[1] = '{4'd5, 88};   tbl[2] = '{4'd5, 82};
        tbl[3] = '{4'd6, 101};  tbl[4] = '{4'd6, 107};  tbl[5] = '{4'd12, 194};
        tbl[6] = '{4'd12, 200}; tbl[7] = '{4'd13, 213}; tbl[8] = '{4'd13, 219};
        tbl[9] = '{4'd4, 0};

        repeat (3) @(negedge clk);
        chk("rst_rx_r", rx_r, 0);
        chk("rst_rx_i", rx_i, 0);
        chk("rst_ready", demap_ready, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // Subframe A, v_shift=2, into bank 0
        stream(2, 0, -1, 1'b1, 168);
        chk("a_ready_lat1", demap_ready, 0);
        @(negedge clk);
        chk("a_ready_lat2", demap_ready, 1);
        for (int i = 0; i < 10; i++) begin
            do_read(tbl[i].col, 1'b0);
            chk($sformatf("tbl%0d_r", i), rx_r, tbl[i].exp_r);
            chk($sformatf("tbl%0d_i", i), rx_i, -tbl[i].exp_r);
        end

        // Subframe B, v_shift=0, fills bank 1 while bank 0 is still held
        stream(0, 0, -1, 1'b1, 168);
        repeat (2) @(negedge clk);
        chk("pp_ready_hold", demap_ready, 1);
        read_chk("pp_old6", 6, 101);
        ack();
        chk("pp_ready_drop", demap_ready, 0);
        @(negedge clk);
        chk("pp_ready_rise", demap_ready, 1);
        read_chk("pp_b5a", 5, 80);
        read_chk("pp_b5b", 5, 86);

        // Subframe C fills bank 0, subframe D finds no free bank
        stream(2, 1000, -1, 1'b1, 168);
        ovf0 = ovf_cnt;
        stream(0, 2000, -1, 1'b1, 168);
        repeat (2) @(negedge clk);
        chk("ovf_pulses", ovf_cnt - ovf0, 1);
        chk("ovf_no_ferr", ferr_cnt, 0);
        ack();
        @(negedge clk);
        chk("ovf_ready_c", demap_ready, 1);
        read_chk("ovf_c5", 5, 1082);
        read_chk("ovf_c13", 13, 1213);
        ack();
        repeat (2) @(negedge clk);
        chk("empty_ready", demap_ready, 0);
        do_read(6, 1'b0);
        chk("notready_hold", rx_r, 1213);

        // Incomplete subframe: last NRS RE (sym 13, sc 11) missing
        ferr0 = ferr_cnt;
        stream(2, 0, 167, 1'b1, 168);
        repeat (2) @(negedge clk);
        chk("inc_ferr", ferr_cnt - ferr0, 1);
        chk("inc_ready", demap_ready, 0);

        // Restart mid-fill, then a good subframe in the same bank
        stream(2, 0, -1, 1'b0, 30);
        stream(2, 0, -1, 1'b1, 168);
        @(negedge clk);
        chk("restart_ferr", ferr_cnt - ferr0, 2);
        chk("restart_ready", demap_ready, 1);
        read_chk("restart_5", 5, 82);

        // v_shift=7 subframe into the other bank, then read+ack on one cycle
        stream(7, 0, -1, 1'b1, 168);
        @(negedge clk);
        do_read(12, 1'b1);
        chk("rdack_old_r", rx_r, 194);
        chk("rdack_ready_drop", demap_ready, 0);
        @(negedge clk);
        chk("vs7_ready", demap_ready, 1);
        read_chk("vs7_5a", 5, 81);
        read_chk("vs7_5b", 5, 87);
        read_chk("vs7_6", 6, 100);
        read_chk("vs7_13", 13, 212);

        // Reset asserted together with a read
        demap_read = 1'b1;
        col_demap  = 4'd6;
        rst        = 1'b1;
        @(negedge clk);
        demap_read = 1'b0;
        chk("mid_rst_rx_r", rx_r, 0);
        chk("mid_rst_rx_i", rx_i, 0);
        chk("mid_rst_ready", demap_ready, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", demap_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
